// File: rtl/sdrd_rx_assembler_if.sv
// ----------------------------------------------------------------------------
// sdrd_rx_assembler_if
//
// Host bus bundle for the SDRD receive assembler. The host decodes the
// serial-section window with SSER/BA13/BA12/BR_W and selects a register
// with BA; the assembler answers on BD and raises BD_OE while it drives.
//
// Signals:
//   SSER     active-low serial-section select
//   BA13     address decode bit, must be 0 for the window
//   BA12     address decode bit, must be 1 for the window
//   BA[3:0]  bus address bits [7:4], register select (8 = data, 9 = status)
//   BR_W     1 = read, 0 = write
//   BD[7:0]  read data from the assembler
//   BD_OE    assembler is driving BD
//
// Modports:
//   master  host side, drives the address/control lines
//   slave   assembler side, drives BD/BD_OE
// ----------------------------------------------------------------------------
interface sdrd_rx_assembler_if;
  logic       SSER;
  logic       BA13;
  logic       BA12;
  logic [3:0] BA;
  logic       BR_W;
  logic [7:0] BD;
  logic       BD_OE;

  modport master (
    output SSER, BA13, BA12, BA, BR_W,
    input  BD, BD_OE
  );

  modport slave (
    input  SSER, BA13, BA12, BA, BR_W,
    output BD, BD_OE
  );
endinterface

// File: rtl/sdrd_rx_assembler.sv
// ----------------------------------------------------------------------------
// sdrd_rx_assembler
//
// Receives the SDRD bit stream from the serial-read sequencer, assembles
// LSB-first characters in a shift register and moves each completed
// character into a holding register flagged by SDRDY. The host reads the
// held byte (address 8) or a status word (address 9) through the decoded
// serial-section window; a data read acknowledges the byte.
//
// Build option:
//   SDRD_PARITY_EN  characters carry a trailing odd-parity bit; SDPERR
//                   reports a parity error on the held byte. Without it
//                   characters are DATA_W bits and SDPERR is tied to 0.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus          host bus window (sdrd_rx_assembler_if.slave)
//   SDRD         serial data bit, sampled only when SDSTB=1
//   SDSTB        single-cycle bit-valid strobe
//   SDSYNC       single-cycle frame-start pulse
//   SDRDY        holding register holds an unread byte
//   SDOVR        a byte was overwritten before it was read
//   SDPERR       parity error on the held byte
// ----------------------------------------------------------------------------
module sdrd_rx_assembler #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdrd_rx_assembler_if.slave    bus,
  input  logic                  SDRD,
  input  logic                  SDSTB,
  input  logic                  SDSYNC,
  output logic                  SDRDY,
  output logic                  SDOVR,
  output logic                  SDPERR
);

`ifdef SDRD_PARITY_EN
  localparam int N = DATA_W + 1;
`else
  localparam int N = DATA_W;
`endif
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    HUNT,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      sr_q, sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              rdy_q, rdy_d;
  logic              ovr_q, ovr_d;
  logic              perr_q, perr_d;

  logic [N-1:0]      shifted;
  logic              complete;
  logic              sel, data_rd, status_rd;
  logic [7:0]        hold_bd;

  // Host window decode; purely combinational so BD has no cycle latency.
  assign sel       = ~bus.SSER & ~bus.BA13 & bus.BA12 & bus.BR_W;
  assign data_rd   = sel & (bus.BA == 4'h8);
  assign status_rd = sel & (bus.BA == 4'h9);
  assign hold_bd   = 8'(hold_q);

  assign bus.BD_OE = data_rd | status_rd;
  assign bus.BD    = data_rd   ? hold_bd :
                     status_rd ? {5'b0, SDPERR, SDOVR, SDRDY} :
                                 8'h00;

  assign SDRDY  = rdy_q;
  assign SDOVR  = ovr_q;
  assign SDPERR = perr_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can leave
    // one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    hold_d   = hold_q;
    rdy_d    = rdy_q;
    ovr_d    = ovr_q;
    perr_d   = perr_q;
    complete = 1'b0;
    shifted  = {SDRD, sr_q[N-1:1]};

    // SDSYNC restarts the character from any state; a coincident strobe
    // is kept as bit 0 of the new character.
    if (SDSYNC) begin
      state_d = SHIFT;
      if (SDSTB) begin
        sr_d  = shifted;
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (state_q == SHIFT && SDSTB) begin
      sr_d = shifted;
      if (cnt_q == CNT_LAST) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (data_rd) begin
      rdy_d  = 1'b0;
      ovr_d  = 1'b0;
      perr_d = 1'b0;
    end

    // Completion overrides the read acknowledge above: the new byte stays
    // flagged, and a byte that was just read is not counted as overrun.
    if (complete) begin
      hold_d = shifted[DATA_W-1:0];
      rdy_d  = 1'b1;
      if (rdy_q && !data_rd) begin
        ovr_d = 1'b1;
      end
`ifdef SDRD_PARITY_EN
      // Odd parity: data plus parity bit must hold an odd number of ones.
      perr_d = ~^shifted;
`endif
    end

`ifndef SDRD_PARITY_EN
    perr_d = 1'b0;
`endif
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  // hold is reset too, so a data read right after reset returns 8'h00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sr_q    <= '0;
      hold_q  <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_sdrd_rx_assembler.sv
// ----------------------------------------------------------------------------
// tb_sdrd_rx_assembler
//
// Self-checking bench for sdrd_rx_assembler. Characters are driven
// LSB-first; the byte each one should leave in the holding register is
// pushed to exp_q and popped when a data read presents it on BD.
// Inputs change on the falling edge; outputs are sampled 1 ns later,
// well before the next rising edge.
// ----------------------------------------------------------------------------
module tb_sdrd_rx_assembler;

  localparam int DATA_W = 8;
  localparam logic [1:0] M_IDLE = 2'd0, M_DATA = 2'd1, M_STAT = 2'd2, M_WR = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SDRD = 1'b0, SDSTB = 1'b0, SDSYNC = 1'b0;
  logic SDRDY, SDOVR, SDPERR;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  sdrd_rx_assembler_if bus_if ();

  sdrd_rx_assembler #(.DATA_W(DATA_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if),
    .SDRD   (SDRD),
    .SDSTB  (SDSTB),
    .SDSYNC (SDSYNC),
    .SDRDY  (SDRDY),
    .SDOVR  (SDOVR),
    .SDPERR (SDPERR)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: inputs applied at the falling edge, settled
  // 1 ns later; the following rising edge consumes them.
  task automatic set_inputs(input logic stb, input logic sync, input logic d,
                            input logic [1:0] mode);
    @(negedge clk);
    SDSTB  = stb;
    SDSYNC = sync;
    SDRD   = d;
    bus_if.BA13 = 1'b0;
    bus_if.BA12 = 1'b1;
    bus_if.SSER = (mode == M_IDLE);
    bus_if.BR_W = (mode != M_WR);
    bus_if.BA   = (mode == M_STAT) ? 4'h9 : 4'h8;
    #1;
  endtask

  // Optional SDSYNC, then nbits strobes of val LSB-first; the final strobe
  // carries bus mode last_mode. The byte that should end up held is queued.
  task automatic send_char(input logic [8:0] val, input int nbits,
                           input logic sync, input logic [1:0] last_mode);
    if (sync) set_inputs(1'b0, 1'b1, 1'b0, M_IDLE);
    exp_q.push_back(val[7:0]);
    for (int i = 0; i < nbits; i++)
      set_inputs(1'b1, 1'b0, val[i], (i == nbits - 1) ? last_mode : M_IDLE);
  endtask

  task automatic status_is(input string name, input logic [7:0] exp);
    set_inputs(1'b0, 1'b0, 1'b0, M_STAT);
    n_cmp++;
    if (bus_if.BD !== exp || bus_if.BD_OE !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: status BD=%h OE=%b, want BD=%h OE=1", name, bus_if.BD, bus_if.BD_OE, exp);
    end
  endtask

  task automatic data_read(input string name);
    logic [7:0] exp;
    set_inputs(1'b0, 1'b0, 1'b0, M_DATA);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: data BD=%h read with no byte expected", name, bus_if.BD);
    end else begin
      exp = exp_q.pop_front();
      if (bus_if.BD !== exp || bus_if.BD_OE !== 1'b1) begin
        n_bad++;
        $display("FAIL %s: data BD=%h OE=%b, want BD=%h OE=1", name, bus_if.BD, bus_if.BD_OE, exp);
      end
    end
  endtask

  task automatic test_reset();
    set_inputs(1'b0, 1'b0, 1'b0, M_IDLE);
    n_cmp++;
    if ({SDRDY, SDOVR, SDPERR, bus_if.BD_OE, bus_if.BD} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_idle: rdy/ovr/perr/oe=%b%b%b%b BD=%h, want 0000 00",
               SDRDY, SDOVR, SDPERR, bus_if.BD_OE, bus_if.BD);
    end
    status_is("reset_status", 8'h00);
    set_inputs(1'b0, 1'b0, 1'b0, M_DATA);
    n_cmp++;
    if (bus_if.BD !== 8'h00 || bus_if.BD_OE !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_data: BD=%h OE=%b, want 00 1", bus_if.BD, bus_if.BD_OE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hunt();
    for (int i = 0; i < 8; i++) set_inputs(1'b1, 1'b0, 1'b1, M_IDLE);
    set_inputs(1'b0, 1'b0, 1'b0, M_IDLE);
    n_cmp++;
    if (SDRDY !== 1'b0) begin
      n_bad++;
      $display("FAIL hunt_rdy: SDRDY=%b, want 0", SDRDY);
    end
    status_is("hunt_status", 8'h00);
  endtask

  task automatic test_basic();
    send_char(9'h0A5, 8, 1'b1, M_IDLE);
    n_cmp++;
    if (SDRDY !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_latency: SDRDY=%b before completing edge, want 0", SDRDY);
    end
    set_inputs(1'b0, 1'b0, 1'b0, M_IDLE);
    n_cmp++;
    if (SDRDY !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_rdy: SDRDY=%b, want 1", SDRDY);
    end
    data_read("basic_data");
    set_inputs(1'b0, 1'b0, 1'b0, M_IDLE);
    n_cmp++;
    if (SDRDY !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ack: SDRDY=%b after read, want 0", SDRDY);
    end
  endtask

  task automatic test_overrun();
    // Second character follows the first with no SDSYNC and no gap.
    send_char(9'h03C, 8, 1'b1, M_IDLE);
    send_char(9'h0C3, 8, 1'b0, M_IDLE);
    status_is("ovr_status", 8'h03);
    void'(exp_q.pop_front());  // 3C was overwritten unread
    data_read("ovr_data");
    status_is("ovr_cleared", 8'h00);
  endtask

  task automatic test_simultaneous();
    // Leave hold=11 with SDRDY=1 and SDOVR=1 before the colliding read.
    send_char(9'h022, 8, 1'b1, M_IDLE);
    send_char(9'h011, 8, 1'b0, M_IDLE);
    void'(exp_q.pop_front());  // 22 was overwritten unread
    send_char(9'h055, 8, 1'b1, M_DATA);
    n_cmp++;
    if (bus_if.BD !== exp_q[0]) begin
      n_bad++;
      $display("FAIL simul_old_bd: BD=%h during completion, want %h", bus_if.BD, exp_q[0]);
    end
    void'(exp_q.pop_front());  // 11 consumed by that read
    status_is("simul_status", 8'h01);
    data_read("simul_data");
  endtask

  task automatic test_resync();
    struct packed { logic sser, ba13, ba12, br_w; logic [3:0] ba; logic oe; } tbl[6];
    set_inputs(1'b0, 1'b1, 1'b0, M_IDLE);
    for (int i = 0; i < 4; i++) set_inputs(1'b1, 1'b0, 1'b1, M_IDLE);
    set_inputs(1'b1, 1'b1, 1'b1, M_IDLE);
    for (int i = 0; i < 7; i++) set_inputs(1'b1, 1'b0, 1'b0, M_IDLE);
    exp_q.push_back(8'h01);
    status_is("resync_status", 8'h01);

    // Writes inside the window and out-of-window accesses never drive BD.
    set_inputs(1'b0, 1'b0, 1'b0, M_WR);
    n_cmp++;
    if (bus_if.BD_OE !== 1'b0 || bus_if.BD !== 8'h00) begin
      n_bad++;
      $display("FAIL write_ignored: BD=%h OE=%b, want 00 0", bus_if.BD, bus_if.BD_OE);
    end
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h8, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      SDSTB = 1'b0; SDSYNC = 1'b0;
      bus_if.SSER = tbl[i].sser; bus_if.BA13 = tbl[i].ba13;
      bus_if.BA12 = tbl[i].ba12; bus_if.BR_W = tbl[i].br_w; bus_if.BA = tbl[i].ba;
      #1;
      n_cmp++;
      if (bus_if.BD_OE !== tbl[i].oe || bus_if.BD !== (tbl[i].oe ? 8'h01 : 8'h00)) begin
        n_bad++;
        $display("FAIL decode[%0d]: BD=%h OE=%b, want OE=%b", i, bus_if.BD, bus_if.BD_OE, tbl[i].oe);
      end
    end
    status_is("no_side_effect", 8'h01);
    data_read("resync_data");
  endtask

  task automatic test_parity();
`ifdef SDRD_PARITY_EN
    send_char(9'h007, 9, 1'b1, M_IDLE);
    status_is("parity_ok", 8'h01);
    data_read("parity_ok_data");
    send_char(9'h107, 9, 1'b0, M_IDLE);
    status_is("parity_err", 8'h05);
    data_read("parity_err_data");
    status_is("parity_cleared", 8'h00);
`else
    // The 9th strobe is bit 0 of the following character.
    send_char(9'h107, 8, 1'b1, M_IDLE);
    set_inputs(1'b1, 1'b0, 1'b1, M_IDLE);
    status_is("noparity_status", 8'h01);
    data_read("noparity_data");
    for (int i = 0; i < 7; i++) set_inputs(1'b1, 1'b0, 1'b0, M_IDLE);
    exp_q.push_back(8'h01);
    status_is("noparity_next", 8'h01);
    data_read("noparity_next_data");
`endif
  endtask

  task automatic test_reset_mid();
    send_char(9'h0F0, 8, 1'b1, M_IDLE);
    for (int i = 0; i < 4; i++) set_inputs(1'b1, 1'b0, 1'b1, M_IDLE);
    void'(exp_q.pop_front());  // F0 is lost to the reset
    @(negedge clk);
    SDSTB = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (SDRDY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: SDRDY=%b right after rst_n fall, want 0", SDRDY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Back in HUNT: strobes without SDSYNC complete nothing.
    for (int i = 0; i < 8; i++) set_inputs(1'b1, 1'b0, 1'b1, M_IDLE);
    status_is("reset_mid_status", 8'h00);
  endtask

  initial begin
    bus_if.SSER = 1'b1; bus_if.BA13 = 1'b0; bus_if.BA12 = 1'b1;
    bus_if.BR_W = 1'b1; bus_if.BA = 4'h8;
    test_reset();
    test_hunt();
    test_basic();
    test_overrun();
    test_simultaneous();
    test_resync();
    test_parity();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drained: %0d bytes never read, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdrd_rx_assembler.md
# sdrd_rx_assembler

Downstream consumer of the serial-read sequencer's SDRD bit stream. Collects SDRD bits on each bit strobe and assembles them into bytes in a shift register. Each completed byte is moved into a holding register and flagged ready. The host bus reads the byte and a status word through the same decoded window the sequencer uses: SSER low, BA13 low, BA12 high, BR_W high.

## Interface
Parameters:
- DATA_W, 8, data bits per character.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- SSER  in  1  active-low serial-section select.
- BA13, BA12  in  1 each  bus address decode bits.
- BA  in  4  bus address bits [7:4], register select.
- BR_W  in  1  bus read (1) / write (0).
- SDRD  in  1  serial data bit from the sequencer; sampled only when SDSTB=1.
- SDSTB  in  1  single-cycle bit-valid strobe.
- SDSYNC  in  1  single-cycle frame-start pulse.
- BD  out  8  read data; combinational, valid while BD_OE=1; 8'h00 otherwise.
- BD_OE  out  1  bus drive enable.
- SDRDY  out  1  holding register holds an unread byte.
- SDOVR  out  1  a byte was overwritten before it was read.
- SDPERR  out  1  parity error on the held byte; constant 0 without the macro.

## Operation
- Window decode: sel = ~SSER & ~BA13 & BA12 & BR_W. A data read is sel & BA==4'h8. A status read is sel & BA==4'h9. BD_OE = data read | status read.
- BD contents:
  - Data read: hold[7:0].
  - Status read: {5'b0, SDPERR, SDOVR, SDRDY}.
- The FSM has two states:
  - HUNT (reset state): SDSTB is ignored. SDSYNC moves to SHIFT with cnt=0.
  - SHIFT: each SDSTB shifts SDRD in LSB-first (sr <= {SDRD, sr[N-1:1]}) and increments cnt.
- Character length N is DATA_W, or DATA_W+1 with parity.
- Character completion: the strobe with cnt==N-1 completes the character.
  - hold <= the data bits including this bit.
  - SDRDY <= 1; cnt <= 0.
  - The FSM stays in SHIFT for the next character.
- SDSYNC in SHIFT: cnt <= 0 and the partial character is discarded. If SDSTB is high in the same cycle, that bit becomes bit 0 (cnt <= 1). The same rule applies to SDSYNC and SDSTB together in HUNT.
- Data read side effect: each clock edge with a data read active clears SDRDY, SDOVR and SDPERR. A status read has no side effects.
- Overrun: SDOVR <= 1 when a character completes while SDRDY=1 and no data read is active in that cycle. hold is overwritten regardless.
- Completion and data read in the same cycle: completion wins.
  - hold loads; SDRDY stays 1.
  - SDOVR is cleared, not set.
  - SDPERR takes the new character's value.
  - BD shows the old hold during that cycle.
- Writes (BR_W=0) inside the window are ignored.

## Timing
- Reset (async, rst_n=0): state=HUNT, cnt=0, sr=0, hold=0, SDRDY=0, SDOVR=0, SDPERR=0. BD=8'h00 and BD_OE=0 unless a read is selected; with a read selected they show the reset values.
- Reset mid-character discards the partial character. rst_n deassertion takes effect on the next edge.
- Latency:
  - SDRDY and hold update on the edge that samples the final SDSTB.
  - They are visible in the following cycle.
  - BD/BD_OE are combinational from the address inputs, with zero cycles of latency.
- Strobes arrive no closer than 1 per cycle; back-to-back SDSTB every cycle is legal.
- cnt wraps N-1 -> 0 on completion. No strobe is lost across the byte boundary.

## Configuration
- SDRD_PARITY_EN defined:
  - N = DATA_W+1; the last bit is odd parity over the data bits.
  - On completion, SDPERR <= (XOR of data bits and parity bit) == 0.
  - The parity bit is not stored in hold.
- SDRD_PARITY_EN undefined:
  - N = DATA_W; no parity logic.
  - SDPERR is tied to 0 and status bit 2 reads 0.

## Test plan
- Reset then strobes without SDSYNC: 8 SDSTB with SDRD=1 in HUNT -> SDRDY stays 0, status read returns 8'h00.
- Basic byte: SDSYNC, then 8 strobes LSB-first carrying 8'hA5 (1,0,1,0,0,1,0,1) -> SDRDY=1 the next cycle. Data read returns 8'hA5 and SDRDY=0 the following cycle.
- Overrun: two characters 8'h3C then 8'hC3 with no read -> status 8'h03, data 8'hC3. After the data read, status is 8'h00.
- Simultaneous completion and read: data read held active during the final strobe of 8'h55, with hold=8'h11 and SDRDY=1 -> BD=8'h11 that cycle. Next cycle SDRDY=1, SDOVR=0, hold=8'h55.
- Resync mid-character: 4 strobes, then SDSYNC with SDSTB=1 (SDRD=1), then 7 strobes of 0 -> hold=8'h01.
- Parity (with SDRD_PARITY_EN):
  - 8'h07 plus parity bit 0 -> SDPERR=0.
  - 8'h07 plus parity bit 1 -> SDPERR=1, status 8'h05.
  - Without the macro, the same 9 strobes give hold=8'h07, and the 9th strobe starts the next character.
